// File: rtl/rv_imm_pkg.sv
// Shared constants for the immediate-decode stage: format codes, the
// RV opcodes that select a format, and the skid-buffer state encoding.
package rv_imm_pkg;

  localparam logic [2:0] FMT_I   = 3'b000;
  localparam logic [2:0] FMT_S   = 3'b001;
  localparam logic [2:0] FMT_B   = 3'b010;
  localparam logic [2:0] FMT_U   = 3'b011;
  localparam logic [2:0] FMT_J   = 3'b100;
  localparam logic [2:0] FMT_Z   = 3'b101;
  localparam logic [2:0] FMT_ILL = 3'b111;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Occupancy of the output/skid register pair.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_TWO   = 2'b10
  } buf_state_e;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: slices the instruction word according
// to the format code and sign/zero-extends the result to XLEN.
module imm_extract
  import rv_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // Format-dependent field gather and extension; unknown codes yield zero.
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (fmt)
      FMT_I:   imm = XLEN'($signed(instr[31:20]));
      FMT_S:   imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      FMT_B:   imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                    instr[11:8], 1'b0}));
      FMT_U:   imm = XLEN'($signed({instr[31:12], 12'b0}));
      FMT_J:   imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                    instr[30:21], 1'b0}));
      FMT_Z:   imm = XLEN'(instr[19:15]);
      default: begin
        imm     = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with a two-entry skid buffer. Decoding
// happens before the registers, so the skid register holds finished results
// and the output register is loaded either from the decoder or the skid.
module imm_decode_stage
  import rv_imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit AUTO_SEL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [2:0]      in_imm_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_target
);

  buf_state_e      state_r, state_s;
  logic [2:0]      auto_fmt_s, fmt_s;
  logic [XLEN-1:0] imm_s, target_s;
  logic            illegal_s;
  logic            acc_s, drn_s;
  logic            load_out_in_s, load_out_skid_s, load_skid_s;

  logic [XLEN-1:0] skid_imm_r, skid_pc_r, skid_target_r;
  logic [2:0]      skid_fmt_r;
  logic            skid_illegal_r;

  // Opcode to format map; SYSTEM splits on funct3[2] (immediate CSR forms).
  always_comb begin
    auto_fmt_s = FMT_ILL;
    case (in_instr[6:0])
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: auto_fmt_s = FMT_I;
      OP_STORE:                           auto_fmt_s = FMT_S;
      OP_BRANCH:                          auto_fmt_s = FMT_B;
      OP_LUI, OP_AUIPC:                   auto_fmt_s = FMT_U;
      OP_JAL:                             auto_fmt_s = FMT_J;
      OP_SYSTEM: begin
        if (in_instr[14]) begin
          auto_fmt_s = FMT_Z;
        end else begin
          auto_fmt_s = FMT_I;
        end
      end
      default:                            auto_fmt_s = FMT_ILL;
    endcase
  end

  // Resolved format: opcode-derived or the external select passed unchanged.
  always_comb begin
    fmt_s = 3'b000;
    if (AUTO_SEL) begin
      fmt_s = auto_fmt_s;
    end else begin
      fmt_s = in_imm_sel;
    end
  end

  imm_extract #(
    .XLEN (XLEN)
  ) u_imm_extract (
    .instr   (in_instr),
    .fmt     (fmt_s),
    .imm     (imm_s),
    .illegal (illegal_s)
  );

  assign target_s = in_pc + imm_s;
  assign acc_s    = in_valid & in_ready;
  assign drn_s    = out_valid & out_ready;

  // Buffer next-state and register load selects.
  always_comb begin
    state_s         = state_r;
    load_out_in_s   = 1'b0;
    load_out_skid_s = 1'b0;
    load_skid_s     = 1'b0;
    case (state_r)
      BUF_EMPTY: begin
        if (acc_s) begin
          state_s       = BUF_ONE;
          load_out_in_s = 1'b1;
        end else begin
          state_s = BUF_EMPTY;
        end
      end
      BUF_ONE: begin
        if (acc_s && drn_s) begin
          state_s       = BUF_ONE;
          load_out_in_s = 1'b1;
        end else if (acc_s) begin
          state_s     = BUF_TWO;
          load_skid_s = 1'b1;
        end else if (drn_s) begin
          state_s = BUF_EMPTY;
        end else begin
          state_s = BUF_ONE;
        end
      end
      BUF_TWO: begin
        if (drn_s) begin
          state_s         = BUF_ONE;
          load_out_skid_s = 1'b1;
        end else begin
          state_s = BUF_TWO;
        end
      end
      default: state_s = BUF_EMPTY;
    endcase
  end

  // State register plus registered handshake flags derived from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= BUF_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_r   <= state_s;
      out_valid <= (state_s != BUF_EMPTY);
      in_ready  <= (state_s != BUF_TWO);
    end
  end

  // Output register: fresh decode on pass-through, skid contents on refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_imm     <= '0;
      out_fmt     <= 3'b000;
      out_illegal <= 1'b0;
      out_pc      <= '0;
      out_target  <= '0;
    end else if (load_out_in_s) begin
      out_imm     <= imm_s;
      out_fmt     <= fmt_s;
      out_illegal <= illegal_s;
      out_pc      <= in_pc;
      out_target  <= target_s;
    end else if (load_out_skid_s) begin
      out_imm     <= skid_imm_r;
      out_fmt     <= skid_fmt_r;
      out_illegal <= skid_illegal_r;
      out_pc      <= skid_pc_r;
      out_target  <= skid_target_r;
    end else begin
      out_imm     <= out_imm;
      out_fmt     <= out_fmt;
      out_illegal <= out_illegal;
      out_pc      <= out_pc;
      out_target  <= out_target;
    end
  end

  // Skid register captures a decoded item arriving while the output stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_imm_r     <= '0;
      skid_fmt_r     <= 3'b000;
      skid_illegal_r <= 1'b0;
      skid_pc_r      <= '0;
      skid_target_r  <= '0;
    end else if (load_skid_s) begin
      skid_imm_r     <= imm_s;
      skid_fmt_r     <= fmt_s;
      skid_illegal_r <= illegal_s;
      skid_pc_r      <= in_pc;
      skid_target_r  <= target_s;
    end else begin
      skid_imm_r     <= skid_imm_r;
      skid_fmt_r     <= skid_fmt_r;
      skid_illegal_r <= skid_illegal_r;
      skid_pc_r      <= skid_pc_r;
      skid_target_r  <= skid_target_r;
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: three instances (auto/32, auto/64, manual/32)
// share one stimulus stream; a queue-based reference model scores all three.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic [2:0]  in_imm_sel;
  logic        out_ready;

  logic        a32_ready, a32_valid, a32_ill, a64_ready, a64_valid, a64_ill;
  logic        m32_ready, m32_valid, m32_ill;
  logic [2:0]  a32_fmt, a64_fmt, m32_fmt;
  logic [31:0] a32_imm, a32_pc, a32_tgt, m32_imm, m32_pc, m32_tgt;
  logic [63:0] a64_imm, a64_pc, a64_tgt;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .AUTO_SEL(1'b1)) dut_a32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a32_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .in_imm_sel(in_imm_sel),
    .out_valid(a32_valid), .out_ready(out_ready), .out_imm(a32_imm),
    .out_fmt(a32_fmt), .out_illegal(a32_ill), .out_pc(a32_pc), .out_target(a32_tgt));

  imm_decode_stage #(.XLEN(64), .AUTO_SEL(1'b1)) dut_a64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a64_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_imm_sel(in_imm_sel),
    .out_valid(a64_valid), .out_ready(out_ready), .out_imm(a64_imm),
    .out_fmt(a64_fmt), .out_illegal(a64_ill), .out_pc(a64_pc), .out_target(a64_tgt));

  imm_decode_stage #(.XLEN(32), .AUTO_SEL(1'b0)) dut_m32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m32_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .in_imm_sel(in_imm_sel),
    .out_valid(m32_valid), .out_ready(out_ready), .out_imm(m32_imm),
    .out_fmt(m32_fmt), .out_illegal(m32_ill), .out_pc(m32_pc), .out_target(m32_tgt));

  // Uniform views of the three instances: 0 = auto/32, 1 = auto/64, 2 = manual/32.
  logic [63:0] o_imm [3];
  logic [63:0] o_pc  [3];
  logic [63:0] o_tgt [3];
  logic [2:0]  o_fmt [3];
  logic        o_ill [3];
  logic        o_vld [3];
  logic        o_rdy [3];
  assign o_imm[0] = {32'd0, a32_imm};  assign o_imm[1] = a64_imm;  assign o_imm[2] = {32'd0, m32_imm};
  assign o_pc[0]  = {32'd0, a32_pc};   assign o_pc[1]  = a64_pc;   assign o_pc[2]  = {32'd0, m32_pc};
  assign o_tgt[0] = {32'd0, a32_tgt};  assign o_tgt[1] = a64_tgt;  assign o_tgt[2] = {32'd0, m32_tgt};
  assign o_fmt[0] = a32_fmt;  assign o_fmt[1] = a64_fmt;  assign o_fmt[2] = m32_fmt;
  assign o_ill[0] = a32_ill;  assign o_ill[1] = a64_ill;  assign o_ill[2] = m32_ill;
  assign o_vld[0] = a32_valid; assign o_vld[1] = a64_valid; assign o_vld[2] = m32_valid;
  assign o_rdy[0] = a32_ready; assign o_rdy[1] = a64_ready; assign o_rdy[2] = m32_ready;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [63:0] pc;
    logic [63:0] tgt;
  } exp_t;

  typedef struct {
    int          dut;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  sel;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [63:0] tgt;
  } vec_t;

  int   n_chk  = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;
  bit   zchk   = 1'b0;
  exp_t sbq [3][$];

  task automatic chk(input int k, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
  endtask

  // Reference decode from the instruction-set rules, using signed arithmetic.
  function automatic exp_t model(input logic [31:0] w, input logic [63:0] pc,
                                 input logic [2:0] sel, input bit auto_m, input bit x64);
    exp_t        e;
    longint      v;
    logic [2:0]  f;
    logic [63:0] mask;
    f = sel;
    if (auto_m) begin
      case (w[6:0])
        7'h03, 7'h13, 7'h1B, 7'h67: f = 3'd0;
        7'h23:                      f = 3'd1;
        7'h63:                      f = 3'd2;
        7'h37, 7'h17:               f = 3'd3;
        7'h6F:                      f = 3'd4;
        7'h73:                      f = w[14] ? 3'd5 : 3'd0;
        default:                    f = 3'd7;
      endcase
    end
    v = 0;
    e.ill = 1'b0;
    case (f)
      3'd0: begin v = longint'(w[31:20]); if (v >= 2048) v -= 4096; end
      3'd1: begin v = longint'(w[31:25]) * 32 + longint'(w[11:7]); if (v >= 2048) v -= 4096; end
      3'd2: begin
        v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      3'd3: begin v = longint'(w[31:12]) * 4096; if (v >= 64'sd2147483648) v -= 64'sd4294967296; end
      3'd4: begin
        v = longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      3'd5: v = longint'(w[19:15]);
      default: e.ill = 1'b1;
    endcase
    mask  = x64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    e.imm = 64'(v) & mask;
    e.fmt = f;
    e.pc  = pc & mask;
    e.tgt = (pc + 64'(v)) & mask;
    return e;
  endfunction

  // Scoreboard: occupancy-derived handshake, head-of-queue data every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        if (zchk) begin
          chk(k, "rst_zero_imm", o_imm[k], 64'd0);
          chk(k, "rst_zero_fmt", {61'd0, o_fmt[k]}, 64'd0);
          chk(k, "rst_zero_ill", {63'd0, o_ill[k]}, 64'd0);
          chk(k, "rst_zero_pc",  o_pc[k], 64'd0);
          chk(k, "rst_zero_tgt", o_tgt[k], 64'd0);
        end
        chk(k, "out_valid", {63'd0, o_vld[k]}, {63'd0, sbq[k].size() > 0});
        chk(k, "in_ready",  {63'd0, o_rdy[k]}, {63'd0, sbq[k].size() < 2});
        if (o_vld[k] && sbq[k].size() > 0) begin
          chk(k, "imm", o_imm[k], sbq[k][0].imm);
          chk(k, "fmt", {61'd0, o_fmt[k]}, {61'd0, sbq[k][0].fmt});
          chk(k, "illegal", {63'd0, o_ill[k]}, {63'd0, sbq[k][0].ill});
          chk(k, "pc", o_pc[k], sbq[k][0].pc);
          chk(k, "target", o_tgt[k], sbq[k][0].tgt);
          if (out_ready) void'(sbq[k].pop_front());
        end
        if (in_valid && o_rdy[k] && !rst)
          sbq[k].push_back(model(in_instr, in_pc, in_imm_sel, k != 2, k == 1));
      end
      zchk = rst;
      if (rst) for (int k = 0; k < 3; k++) sbq[k].delete();
    end
  end

  // Present one item and hold it until accepted (bounded wait).
  task automatic send(input logic [31:0] w, input logic [63:0] pc, input logic [2:0] sel);
    bit a;
    a = 1'b0;
    in_valid = 1'b1; in_instr = w; in_pc = pc; in_imm_sel = sel;
    for (int i = 0; i < 50 && !a; i++) begin
      @(negedge clk);
      a = o_rdy[0];
      @(posedge clk); #1;
    end
    if (!a) chk(0, "send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 12))
      0: w[6:0] = 7'h03;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h1B;  3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h23;  5: w[6:0] = 7'h63;  6: w[6:0] = 7'h37;  7: w[6:0] = 7'h17;
      8: w[6:0] = 7'h6F;  9: w[6:0] = 7'h73;  10: w[6:0] = 7'h73;
      default: w = w;
    endcase
    return w;
  endfunction

  vec_t        vecs [16];
  logic [63:0] bp_pc [4];
  int          idx, got, cyc, nacc;
  bit          held;

  initial begin
    vecs[0]  = '{0, 32'hFFF00093, 64'h0,     3'd6, 64'hFFFFFFFF, 3'd0, 1'b0, 64'hFFFFFFFF};
    vecs[1]  = '{0, 32'hFE112E23, 64'h200,   3'd6, 64'hFFFFFFFC, 3'd1, 1'b0, 64'h1FC};
    vecs[2]  = '{0, 32'hFFDFF06F, 64'h100,   3'd6, 64'hFFFFFFFC, 3'd4, 1'b0, 64'hFC};
    vecs[3]  = '{0, 32'h00800093, 64'hFFFFFFFC, 3'd6, 64'h8,     3'd0, 1'b0, 64'h4};
    vecs[4]  = '{0, 32'h00000463, 64'h10,    3'd6, 64'h8,        3'd2, 1'b0, 64'h18};
    vecs[5]  = '{0, 32'hFE000EE3, 64'h20,    3'd6, 64'hFFFFFFFC, 3'd2, 1'b0, 64'h1C};
    vecs[6]  = '{0, 32'h12345097, 64'h1000,  3'd6, 64'h12345000, 3'd3, 1'b0, 64'h12346000};
    vecs[7]  = '{0, 32'h30001073, 64'h0,     3'd6, 64'h300,      3'd0, 1'b0, 64'h300};
    vecs[8]  = '{0, 32'h0000007F, 64'h40,    3'd0, 64'h0,        3'd7, 1'b1, 64'h40};
    vecs[9]  = '{1, 32'h800000B7, 64'h0,     3'd6, 64'hFFFFFFFF80000000, 3'd3, 1'b0, 64'hFFFFFFFF80000000};
    vecs[10] = '{1, 32'h300FD073, 64'h100,   3'd6, 64'h1F,       3'd5, 1'b0, 64'h11F};
    vecs[11] = '{1, 32'h00800093, 64'hFFFFFFFFFFFFFFFC, 3'd6, 64'h8, 3'd0, 1'b0, 64'h4};
    vecs[12] = '{2, 32'hFFF00093, 64'h40,    3'd6, 64'h0,        3'd6, 1'b1, 64'h40};
    vecs[13] = '{2, 32'hFE112E23, 64'h200,   3'd1, 64'hFFFFFFFC, 3'd1, 1'b0, 64'h1FC};
    vecs[14] = '{2, 32'h300FD073, 64'h0,     3'd5, 64'h1F,       3'd5, 1'b0, 64'h1F};
    vecs[15] = '{2, 32'h0000007F, 64'h8,     3'd7, 64'h0,        3'd7, 1'b1, 64'h8};

    rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_pc = 64'd0; in_imm_sel = 3'd0;
    out_ready = 1'b1; mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors, one-cycle latency, no back-pressure.
    foreach (vecs[i]) begin
      send(vecs[i].instr, vecs[i].pc, vecs[i].sel);
      @(negedge clk);
      chk(vecs[i].dut, $sformatf("vec%0d_valid", i), {63'd0, o_vld[vecs[i].dut]}, 64'd1);
      chk(vecs[i].dut, $sformatf("vec%0d_imm", i), o_imm[vecs[i].dut], vecs[i].imm);
      chk(vecs[i].dut, $sformatf("vec%0d_fmt", i), {61'd0, o_fmt[vecs[i].dut]}, {61'd0, vecs[i].fmt});
      chk(vecs[i].dut, $sformatf("vec%0d_ill", i), {63'd0, o_ill[vecs[i].dut]}, {63'd0, vecs[i].ill});
      chk(vecs[i].dut, $sformatf("vec%0d_tgt", i), o_tgt[vecs[i].dut], vecs[i].tgt);
      @(posedge clk); #1;
    end

    // Back-pressure: A..D streamed while the sink stalls for three cycles.
    bp_pc[0] = 64'hA00; bp_pc[1] = 64'hB00; bp_pc[2] = 64'hC00; bp_pc[3] = 64'hD00;
    out_ready = 1'b0; idx = 0; got = 0; cyc = 0;
    while (got < 4 && cyc < 40) begin
      if (cyc == 3) out_ready = 1'b1;
      in_valid = (idx < 4);
      in_instr = 32'h00100093; in_pc = bp_pc[idx < 4 ? idx : 3]; in_imm_sel = 3'd0;
      @(negedge clk);
      if (cyc == 1) chk(0, "bp_ready_at_B", {63'd0, o_rdy[0]}, 64'd1);
      if (cyc == 2) chk(0, "bp_ready_after_B", {63'd0, o_rdy[0]}, 64'd0);
      if (o_vld[0] && out_ready) begin
        chk(0, "bp_order", o_pc[0], bp_pc[got]);
        got++;
      end
      if (in_valid && o_rdy[0]) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk(0, "bp_count", 64'(got), 64'd4);

    // Reset while both registers hold items; concurrent in_valid is dropped.
    out_ready = 1'b0;
    send(32'h00500093, 64'h111, 3'd0);
    send(32'h00600093, 64'h222, 3'd0);
    @(negedge clk);
    chk(0, "two_state_ready", {63'd0, o_rdy[0]}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; in_instr = 32'h00700093; in_pc = 64'h333;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk(0, "rst_valid", {63'd0, o_vld[0]}, 64'd0);
    chk(0, "rst_ready", {63'd0, o_rdy[0]}, 64'd1);
    chk(0, "rst_pc", o_pc[0], 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk(0, "no_stale", {63'd0, o_vld[0]}, 64'd0);
    end
    @(posedge clk); #1;

    // Full throughput with a permanently ready sink.
    nacc = 0;
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1; in_instr = rnd_instr(); in_pc = {$urandom, $urandom}; in_imm_sel = 3'($urandom);
      @(negedge clk);
      if (o_rdy[0]) nacc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk(0, "throughput", 64'(nacc), 64'd50);

    // Randomised valid/ready; items are held until accepted.
    nacc = 0; cyc = 0; held = 1'b0;
    while (nacc < 10000 && cyc < 60000) begin
      if (!held) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_instr = rnd_instr(); in_pc = {$urandom, $urandom}; in_imm_sel = 3'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && o_rdy[0]) begin
        nacc++;
        held = 1'b0;
      end else begin
        held = in_valid;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk(0, "rand_count", 64'(nacc), 64'd10000);
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk(k, "drained", 64'(sbq[k].size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, parametrised immediate-decode stage between instruction fetch and execute in the pipelined RISC-V core. It accepts one instruction per cycle over a valid/ready handshake and produces the XLEN-wide immediate, the decoded format, an illegal-format flag and the branch/jump target `pc + imm`. A two-entry skid buffer keeps full throughput under back-pressure. In auto-select mode it derives the immediate format from the opcode; in manual mode it takes an external select.

## Interface
- `XLEN`, 32: datapath width. Only 32 and 64 are legal; the immediate is extended to XLEN.
- `AUTO_SEL`, 1: 1 = format derived from `in_instr[6:0]`; 0 = format taken from `in_imm_sel`.
- `clk`  in  1  the single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream holds a valid instruction.
- `in_ready`  out  1  the stage can accept this cycle.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  XLEN  PC of the instruction.
- `in_imm_sel`  in  3  format select; ignored when `AUTO_SEL`=1.
- `out_valid`  out  1  the output bundle is valid.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_imm`  out  XLEN  extended immediate.
- `out_fmt`  out  3  resolved format code.
- `out_illegal`  out  1  format unresolvable; `out_imm` is 0.
- `out_pc`  out  XLEN  PC, passed through.
- `out_target`  out  XLEN  `out_pc + out_imm`, modulo 2^XLEN.

## Operation
- **Format codes:**
  - 000 I: `instr[31:20]`, sign-extended.
  - 001 S: `{instr[31:25], instr[11:7]}`, sign-extended.
  - 010 B: `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`, sign-extended.
  - 011 U: `{instr[31:12], 12'b0}`, sign-extended to XLEN (bit 31 replicated when XLEN=64).
  - 100 J: `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`, sign-extended.
  - 101 Z: CSR uimm `instr[19:15]`, zero-extended.
  - 110 and 111: illegal; imm = 0, `out_illegal` = 1.
- **Auto map (`AUTO_SEL`=1):**
  - 0000011, 0010011, 0011011, 1100111 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - 1110011 → Z if `instr[14]`=1, else I
  - any other opcode → illegal with `out_fmt` = 111.
- **Manual mode (`AUTO_SEL`=0):** `out_fmt` = `in_imm_sel` unchanged, including the illegal codes.
- `out_target` is computed for every format; consumers ignore it where it is meaningless.
- **Buffer states:**
  - EMPTY: `out_valid`=0, `in_ready`=1.
  - ONE: output register valid, `in_ready`=1.
  - TWO: output register and skid register both valid, `in_ready`=0.
- **Transitions** (acc = `in_valid & in_ready`, drn = `out_valid & out_ready`):
  - EMPTY + acc → ONE.
  - ONE + acc & !drn → TWO (new item goes to skid).
  - ONE + !acc & drn → EMPTY.
  - ONE + acc & drn → ONE (new item goes to output register).
  - TWO + drn → ONE (skid moves to output register).
  - All other cases hold state.
- FIFO order is strictly preserved. The skid register stores already-decoded results.
- `in_ready` is a register output. It never combinationally depends on `out_ready`.

## Timing
- Latency: an instruction accepted at edge N is presented at `out_*` after edge N, i.e. 1 cycle.
- Throughput: 1 per cycle while `out_ready`=1.
- `out_*` are stable while `out_valid=1 & out_ready=0`.
- Reset, any cycle including mid-stream:
  - next state EMPTY; `out_valid`=0, `in_ready`=1.
  - `out_imm`, `out_fmt`, `out_illegal`, `out_pc`, `out_target` all = 0.
  - buffered items are discarded.
  - an `in_valid` coinciding with `rst` is not accepted.
- Adder wrap-around: `pc` = 0xFFFFFFFC plus imm +8 gives `out_target` = 0x00000004 (XLEN=32); no overflow flag.

## Structure
- **Shared package `rv_imm_pkg`:**
  - format code constants `FMT_I`..`FMT_Z`, `FMT_ILL`.
  - opcode constants: `OP_LOAD`, `OP_IMM`, `OP_IMM32`, `OP_JALR`, `OP_STORE`, `OP_BRANCH`, `OP_LUI`, `OP_AUIPC`, `OP_JAL`, `OP_SYSTEM`.
- **Sub-module `imm_extract`:** combinational `(instr, fmt) → (imm, illegal)`, parametrised by XLEN. It is instantiated once, before the output/skid registers.
- The opcode-to-format mapping and the skid-buffer control live in `imm_decode_stage`.

## Test plan
- **Auto-mode formats, XLEN=32, no back-pressure:** each instruction below is presented, with `out_valid` 1 cycle later.
  - 0xFFF00093 (addi -1) → imm 0xFFFFFFFF, fmt 000.
  - 0xFE112E23 (sw -4) → 0xFFFFFFFC, fmt 001.
  - 0xFFDFF06F (jal -4) with pc 0x100 → imm 0xFFFFFFFC, target 0x000000FC.
- **U and Z formats, XLEN=64:**
  - 0x800000B7 (lui) → imm 0xFFFFFFFF80000000.
  - 0x300FD073 (csrrwi, uimm 31) → imm 0x1F, fmt 101.
- **Illegal encodings:**
  - opcode 0x7F in auto mode → `out_illegal`=1, imm 0, fmt 111.
  - manual mode with `in_imm_sel`=110 → `out_illegal`=1.
- **Back-pressure:** stream A, B, C, D with `out_ready`=0 for 3 cycles.
  - A and B are accepted; `in_ready` drops the cycle after B is accepted.
  - After `out_ready` rises, the output order is A, B, C, D with no loss or duplication.
- **Reset mid-stream:** assert `rst` in the TWO state.
  - Next cycle: `out_valid`=0, `in_ready`=1, all data outputs 0.
  - No stale item appears afterwards.
- **Randomised valid/ready:** 10k instructions checked against a reference model.
  - Order and data must match the model.
  - Throughput must reach 1 per cycle when `out_ready` is held at 1.
